// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select encoding and PC increment shared by fetch, hazard and PC logic.
package pc_pkg;
    typedef enum logic [2:0] {SEL_TRAP, SEL_BR, SEL_HOLD, SEL_RAS, SEL_SEQ} next_pc_sel_e;
    localparam int PC_INC = 4;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [XLEN-1:0]            push_data,
    output logic [XLEN-1:0]            top,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   ptr;
    logic            do_pop;
    assign do_pop = pop && count != '0;
    assign top = mem[ptr];
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !do_pop) begin
            ptr   <= ptr + AW'(1);
            count <= count == CW'(DEPTH) ? count : count + CW'(1);
        end else if (do_pop && !push) begin
            ptr   <= ptr - AW'(1);
            count <= count - CW'(1);
        end
    end
    // Simultaneous push+pop replaces the top in place, leaving pointer and count alone.
    always_ff @(posedge i_clk) begin
        if (push) mem[do_pop ? ptr : ptr + AW'(1)] <= push_data;
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with trap/branch redirect, stall, RAS return prediction and misalign flag.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              RAS_DEPTH  = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_stall,
    input  logic                           i_trap_vld,
    input  logic [XLEN-1:0]                i_trap_vec,
    input  logic                           i_br_vld,
    input  logic [XLEN-1:0]                i_br_target,
    input  logic                           i_call,
    input  logic                           i_ret,
    output logic [XLEN-1:0]                o_pc,
    output logic [XLEN-1:0]                o_pc_4,
    output logic                           o_misalign,
    output logic [$clog2(RAS_DEPTH+1)-1:0] o_ras_count,
    output logic                           o_ras_full,
    output logic                           o_ras_empty
);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));
    next_pc_sel_e    sel;
    logic [XLEN-1:0] ras_top, target, next_pc;
    logic            redirect, ras_push, ras_pop;
    always_comb begin
        sel = i_trap_vld ? SEL_TRAP : i_br_vld ? SEL_BR : i_stall ? SEL_HOLD :
              (i_ret && !o_ras_empty) ? SEL_RAS : SEL_SEQ;
    end
    assign redirect = sel == SEL_TRAP || sel == SEL_BR;
    assign target   = sel == SEL_TRAP ? i_trap_vec : i_br_target;
    assign next_pc  = redirect ? (target & ALIGN_MASK) : sel == SEL_HOLD ? o_pc :
                      sel == SEL_RAS ? ras_top : o_pc_4;
    // The stack only moves when the fetch actually advances along the sequential/return path.
    assign ras_push    = i_call && (sel == SEL_RAS || sel == SEL_SEQ);
    assign ras_pop     = sel == SEL_RAS;
    assign o_pc_4      = o_pc + XLEN'(PC_INC);
    assign o_ras_full  = o_ras_count == ($clog2(RAS_DEPTH+1))'(RAS_DEPTH);
    assign o_ras_empty = o_ras_count == '0;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pc       <= RESET_VEC;
            o_misalign <= 1'b0;
        end else begin
            o_pc       <= next_pc;
            o_misalign <= redirect && ((target & ~ALIGN_MASK) != '0);
        end
    end
    pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (o_pc_4),
        .top       (ras_top),
        .count     (o_ras_count)
    );
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenario tests for pc_gen with hand-computed expectations.
module tb_pc_gen;
    logic        i_clk = 0, i_rst = 1, i_stall = 0, i_trap_vld = 0, i_br_vld = 0, i_call = 0, i_ret = 0;
    logic [31:0] i_trap_vec = '0, i_br_target = '0;
    logic [31:0] o_pc, o_pc_4;
    logic        o_misalign, o_ras_full, o_ras_empty;
    logic [2:0]  o_ras_count;
    int          n_chk = 0, n_fail = 0;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .RAS_DEPTH(4), .ALIGN_BITS(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_trap_vld(i_trap_vld),
        .i_trap_vec(i_trap_vec), .i_br_vld(i_br_vld), .i_br_target(i_br_target),
        .i_call(i_call), .i_ret(i_ret), .o_pc(o_pc), .o_pc_4(o_pc_4), .o_misalign(o_misalign),
        .o_ras_count(o_ras_count), .o_ras_full(o_ras_full), .o_ras_empty(o_ras_empty)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp);
        n_chk++;
        if (o_pc !== exp) begin n_fail++; $display("FAIL %s o_pc got %h exp %h", name, o_pc, exp); end
    endtask

    task automatic chk_mis(input string name, input logic exp);
        n_chk++;
        if (o_misalign !== exp) begin n_fail++; $display("FAIL %s o_misalign got %b exp %b", name, o_misalign, exp); end
    endtask

    task automatic chk_cnt(input string name, input logic [2:0] exp);
        n_chk++;
        if (o_ras_count !== exp) begin n_fail++; $display("FAIL %s o_ras_count got %0d exp %0d", name, o_ras_count, exp); end
        n_chk++;
        if (o_ras_empty !== (exp == 0)) begin n_fail++; $display("FAIL %s o_ras_empty got %b exp %b", name, o_ras_empty, exp == 0); end
        n_chk++;
        if (o_ras_full !== (exp == 4)) begin n_fail++; $display("FAIL %s o_ras_full got %b exp %b", name, o_ras_full, exp == 4); end
    endtask

    task automatic branch_to(input logic [31:0] t);
        i_br_vld = 1; i_br_target = t;
        step();
        i_br_vld = 0;
    endtask

    task automatic test_reset();
        step(); step();
        chk_pc("reset_pc", 32'h0); chk_mis("reset_mis", 1'b0); chk_cnt("reset_ras", 3'd0);
        i_rst = 0;
        chk_pc("rel_pc0", 32'h0);
        step(); chk_pc("rel_pc1", 32'h4);
        step(); chk_pc("rel_pc2", 32'h8);
        i_br_vld = 1; i_br_target = 32'h300;
        #2 i_rst = 1;
        #1 chk_pc("async_rst_pc", 32'h0);
        step();
        i_rst = 0; i_br_vld = 0;
        chk_pc("mid_rst_pc0", 32'h0);
        step(); chk_pc("mid_rst_pc1", 32'h4);
        step(); chk_pc("mid_rst_pc2", 32'h8);
    endtask

    task automatic test_priority();
        i_trap_vld = 1; i_trap_vec = 32'h100; i_br_vld = 1; i_br_target = 32'h200; i_stall = 1;
        step();
        i_trap_vld = 0; i_br_vld = 0;
        chk_pc("prio_trap", 32'h100); chk_mis("prio_mis", 1'b0);
        i_br_vld = 1; i_br_target = 32'h200;
        step();
        i_br_vld = 0; i_stall = 0;
        chk_pc("prio_br_over_stall", 32'h200);
    endtask

    task automatic test_stall();
        branch_to(32'h40);
        chk_pc("stall_start", 32'h40);
        i_stall = 1;
        for (int k = 0; k < 3; k++) begin
            step(); chk_pc("stall_hold", 32'h40); chk_mis("stall_mis", 1'b0);
        end
        i_stall = 0;
        step(); chk_pc("stall_release", 32'h44);
    endtask

    task automatic test_misalign();
        branch_to(32'h203);
        chk_pc("mis_br_pc", 32'h200); chk_mis("mis_br_flag", 1'b1);
        step(); chk_pc("mis_next_pc", 32'h204); chk_mis("mis_clear", 1'b0);
        i_trap_vld = 1; i_trap_vec = 32'h101;
        step();
        i_trap_vld = 0;
        chk_pc("mis_trap_pc", 32'h100); chk_mis("mis_trap_flag", 1'b1);
        branch_to(32'h208);
        chk_pc("aligned_br_pc", 32'h208); chk_mis("aligned_br_flag", 1'b0);
    endtask

    task automatic test_ras_call_ret();
        branch_to(32'h10);
        chk_pc("call_at", 32'h10);
        i_call = 1; step(); i_call = 0;
        chk_pc("call_next", 32'h14); chk_cnt("call_cnt", 3'd1);
        i_stall = 1; i_call = 1; step(); i_stall = 0; i_call = 0;
        chk_pc("stall_call_pc", 32'h14); chk_cnt("stall_call_cnt", 3'd1);
        step(); chk_pc("seq_18", 32'h18);
        i_ret = 1; step(); i_ret = 0;
        chk_pc("ret_target", 32'h14); chk_cnt("ret_cnt", 3'd0);
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h1014; exp_ret[1] = 32'h1010; exp_ret[2] = 32'h100c; exp_ret[3] = 32'h1008;
        branch_to(32'h1000);
        i_call = 1;
        for (int k = 0; k < 5; k++) step();
        i_call = 0;
        chk_pc("ovf_pc", 32'h1014); chk_cnt("ovf_cnt", 3'd4);
        i_call = 1; branch_to(32'h2000); i_call = 0;
        chk_cnt("br_call_ignored", 3'd4);
        i_ret = 1;
        for (int k = 0; k < 4; k++) begin
            step(); chk_pc("pop_order", exp_ret[k]); chk_cnt("pop_cnt", 3'(3 - k));
        end
        step(); i_ret = 0;
        chk_pc("underflow_pc", 32'h100c); chk_cnt("underflow_cnt", 3'd0);
    endtask

    task automatic test_call_ret_same();
        branch_to(32'h3000);
        i_call = 1; i_ret = 1; step(); i_call = 0; i_ret = 0;
        chk_pc("cr_empty_pc", 32'h3004); chk_cnt("cr_empty_cnt", 3'd1);
        step(); chk_pc("cr_seq", 32'h3008);
        i_call = 1; i_ret = 1; step(); i_call = 0; i_ret = 0;
        chk_pc("cr_pop_pc", 32'h3004); chk_cnt("cr_swap_cnt", 3'd1);
        i_ret = 1; step(); i_ret = 0;
        chk_pc("cr_new_top", 32'h300c); chk_cnt("cr_final_cnt", 3'd0);
    endtask

    task automatic test_wrap();
        branch_to(32'hFFFF_FFFC);
        n_chk++;
        if (o_pc_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %h exp %h", o_pc_4, 32'h0); end
        step(); chk_pc("wrap_pc", 32'h0); chk_mis("wrap_mis", 1'b0);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_stall();
        test_misalign();
        test_ras_call_ret();
        test_ras_overflow();
        test_call_ret_same();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
